// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial "1011" generator and detector family.
//   seq_state_e  : FSM state encoding (IDLE, SEND, GAP, DONE)
//   SEQ_PAT_W    : default pattern length in bits
//   SEQ_PATTERN  : default pattern value, transmitted MSB first
//   idx_w()      : width of an index counter able to hold 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_out.sv
// -----------------------------------------------------------------------------
// seq_shift_out
// Parallel-load left shifter feeding the serial output. The register shifts in
// zeros, so once a pattern has been fully shifted out the MSB reads 0 without
// any extra gating.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the register
//   load_i  : load data_i (takes priority over shift_i)
//   shift_i : shift left by one, zero fill
//   data_i  : parallel load value
//   msb_o   : current MSB (registered)
// -----------------------------------------------------------------------------
module seq_shift_out #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_gen_1011.sv
// -----------------------------------------------------------------------------
// seq_gen_1011
// Burst generator: on start, emits PATTERN (MSB first) reps times with gap idle
// cycles between repetitions, then pulses done for one cycle.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : begin a burst (sampled in IDLE only)
//   reps      : repetition count, latched with start
//   gap       : idle cycles between repetitions, latched with start
//   abort     : return to IDLE at the next edge, no done pulse
//   out_bit   : serial data, 0 whenever out_valid is 0
//   out_valid : out_bit carries a pattern bit
//   busy      : high in SEND and GAP
//   done      : one-cycle pulse on normal completion
//
// state | meaning
// IDLE  | waiting for start
// SEND  | shifting out one pattern bit per cycle
// GAP   | idle cycles between two repetitions
// DONE  | one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_gen_1011
  import seq_pkg::*;
#(
  parameter int                 PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN = SEQ_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic [3:0]       gap,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = idx_w(PAT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]       gap_len_q, gap_len_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             out_valid_q, busy_q, done_q;

  logic             sh_load, sh_shift;
  logic [PAT_W-1:0] sh_data;

  // Outputs are registered from the next state so the first pattern bit is
  // visible in the cycle right after start is sampled.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = '0;

    if (abort) begin
      // Loading zero clears out_bit together with out_valid.
      state_d   = IDLE;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
      gap_cnt_d = '0;
      sh_load   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rep_cnt_d = reps;
            gap_len_d = gap;
            if (reps != '0) begin
              state_d   = SEND;
              bit_cnt_d = BIT_LAST;
              sh_load   = 1'b1;
              sh_data   = PATTERN;
            end else begin
              state_d = DONE;
            end
          end
        end

        SEND: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            sh_shift  = 1'b1;
          end else begin
            // LSB on the wire this cycle: repetition complete.
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
            sh_load   = 1'b1;
            if (rep_cnt_q == CNT_W'(1)) begin
              state_d = DONE;
            end else if (gap_len_q != 4'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end else begin
              // Back-to-back repetition: reload with no bubble.
              bit_cnt_d = BIT_LAST;
              sh_data   = PATTERN;
            end
          end
        end

        GAP: begin
          if (gap_cnt_q == 4'd1) begin
            state_d   = SEND;
            gap_cnt_d = 4'd0;
            bit_cnt_d = BIT_LAST;
            sh_load   = 1'b1;
            sh_data   = PATTERN;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= (state_d == SEND);
      busy_q      <= (state_d == SEND) || (state_d == GAP);
      done_q      <= (state_d == DONE);
    end
  end

  seq_shift_out #(
    .W (PAT_W)
  ) u_shift (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .msb_o   (out_bit)
  );

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/seq_gen_1011.md
SEQ_GEN_1011 -- requirements
Module: seq_gen_1011

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, giving the pattern value, transmitted MSB first.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the repetition counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a transmission burst.
REQ-007 The block SHALL have port reps, input, CNT_W bits: number of pattern repetitions, sampled with start.
REQ-008 The block SHALL have port gap, input, 4 bits: idle cycles between repetitions, sampled with start.
REQ-009 The block SHALL have port abort, input, 1 bit: terminate the burst immediately.
REQ-010 The block SHALL have port out_bit, output, 1 bit: serial data bit.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_bit carries a pattern bit this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a burst is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal burst completion.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SEND, GAP and DONE.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 In IDLE, start=1 SHALL latch reps and gap; if reps!=0 the FSM SHALL enter SEND, else it SHALL enter DONE.
REQ-017 The first pattern bit (PATTERN[PAT_W-1]) SHALL appear on out_bit with out_valid=1 in the cycle after the edge that samples start.
REQ-018 SEND SHALL emit one pattern bit per cycle, MSB to LSB, for PAT_W consecutive cycles with out_valid=1.
REQ-019 After the LSB of a repetition that is not the last, the FSM SHALL enter GAP if gap!=0; if gap==0 it SHALL begin the next repetition in the immediately following cycle, with no bubble.
REQ-020 GAP SHALL last exactly gap cycles with out_valid=0 and out_bit=0, then SHALL return to SEND.
REQ-021 After the LSB of the last repetition, the FSM SHALL enter DONE; no GAP SHALL follow the final repetition.
REQ-022 DONE SHALL last one cycle with done=1, busy=0 and out_valid=0, then SHALL return to IDLE.
REQ-023 busy SHALL be 1 in SEND and GAP, and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in SEND, GAP and DONE; changes to reps or gap mid-burst SHALL have no effect.
REQ-025 abort=1 in any state SHALL force IDLE at the next edge, with out_valid=0, busy=0 and no done pulse; abort SHALL take priority over start in the same cycle.
REQ-026 out_bit SHALL be 0 whenever out_valid=0.
REQ-027 The repetition counter SHALL decrement once per completed repetition, and reps=2**CNT_W-1 SHALL be honoured without wrap.

Reset
REQ-028 Assertion of reset=0 SHALL asynchronously force IDLE, clear all counters, and drive out_bit=0, out_valid=0, busy=0 and done=0.
REQ-029 Reset asserted mid-burst SHALL discard the burst, with no done pulse after deassertion.
REQ-030 The block SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-031 The state encoding constants IDLE, SEND, GAP and DONE SHALL reside in the shared seq package used by the sequence detector.
REQ-032 The default PATTERN value 4'b1011 SHALL reside in that shared seq package.
REQ-033 The bit-index/shift datapath SHALL be one sub-module, seq_shift_out: a parallel-load shifter with load and shift enables, exposing its MSB.
REQ-034 The FSM and the counters SHALL live in seq_gen_1011.

Verification
REQ-035 reps=1, gap=0, start pulse -> out_bit 1,0,1,1 with out_valid=1 for 4 cycles, then done=1 for 1 cycle, then busy=0.
REQ-036 reps=2, gap=3 -> 1011, then 3 cycles out_valid=0, then 1011; busy high for 11 cycles; done in cycle 12.
REQ-037 Loopback into seq_detect_1011, reps=3, gap=0 -> detector seq_seen pulses exactly 3 times, spaced 4 cycles apart.
REQ-038 reps=0 -> done pulses in the cycle after start; out_valid and busy never assert.
REQ-039 abort in cycle 2 of SEND -> out_valid=0 and busy=0 at the next edge, with no done; a subsequent start runs a full burst.
REQ-040 reset=0 mid-GAP -> all outputs read 0 immediately, without waiting for a clock edge; start after deassertion produces 1011 normally.
